// File: rtl/bound_flash_ctrl.sv
// 16-lamp LED bar sequencer: multi-phase fill/drain pattern started by flick,
// with flick-triggered kickback retreats at lamp checkpoints 5 and 10.
module bound_flash_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        flick,
    output logic [3:0]  out_state,
    output logic [15:0] out
);

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_FILL_0_15   = 4'd1,
        S_DRAIN_15_5  = 4'd2,
        S_FILL_5_10   = 4'd3,
        S_DRAIN_10_0  = 4'd4,
        S_FILL_0_15B  = 4'd5,
        S_DRAIN_15_0  = 4'd6,
        S_KICK_DRAIN  = 4'd7
    } state_t;

    localparam logic [15:0] LAMPS_ALL = 16'hFFFF;
    localparam logic [15:0] LAMPS_0_4 = 16'h001F;
    localparam logic [15:0] LAMPS_0_5 = 16'h003F;
    localparam logic [15:0] LAMPS_0_10 = 16'h07FF;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_out;
    logic [15:0] w_out_nxt;
    logic [15:0] w_fill;
    logic [15:0] w_drain;
    logic        w_checkpoint;

    assign w_fill       = {r_out[14:0], 1'b1};
    assign w_drain      = {1'b0, r_out[15:1]};
    assign w_checkpoint = flick && ((r_out == LAMPS_0_5) || (r_out == LAMPS_0_10));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_out   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
        end
    end

    // A phase change consumes the edge: out holds whenever the state moves.
    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        case (r_state)
            S_IDLE: begin
                w_out_nxt = '0;
                if (flick) w_state_nxt = S_FILL_0_15;
            end
            S_FILL_0_15: begin
                if (r_out == LAMPS_ALL) w_state_nxt = S_DRAIN_15_5;
                else if (w_checkpoint)  w_state_nxt = S_KICK_DRAIN;
                else                    w_out_nxt   = w_fill;
            end
            S_DRAIN_15_5: begin
                if (r_out == LAMPS_0_4) w_state_nxt = S_FILL_5_10;
                else                    w_out_nxt   = w_drain;
            end
            S_FILL_5_10: begin
                if (r_out == LAMPS_0_10) w_state_nxt = flick ? S_DRAIN_15_5 : S_DRAIN_10_0;
                else                     w_out_nxt   = w_fill;
            end
            S_DRAIN_10_0: begin
                if (r_out == '0) w_state_nxt = S_FILL_0_15B;
                else             w_out_nxt   = w_drain;
            end
            S_FILL_0_15B: begin
                if (r_out == LAMPS_ALL) w_state_nxt = S_DRAIN_15_0;
                else if (w_checkpoint)  w_state_nxt = S_DRAIN_10_0;
                else                    w_out_nxt   = w_fill;
            end
            S_DRAIN_15_0: begin
                if (r_out == '0) w_state_nxt = S_IDLE;
                else             w_out_nxt   = w_drain;
            end
            S_KICK_DRAIN: begin
                if (r_out == '0) w_state_nxt = S_FILL_0_15;
                else             w_out_nxt   = w_drain;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_out_nxt   = '0;
            end
        endcase
    end

    assign out_state = r_state;
    assign out       = r_out;

endmodule

// File: tb/tb_bound_flash_ctrl.sv
// Directed bench for bound_flash_ctrl: reset, idle hold, full pattern,
// kickbacks in phases 1 and 3, and reset in the middle of phase 5.
module tb_bound_flash_ctrl;

    logic        clk;
    logic        reset;
    logic        flick;
    logic [3:0]  out_state;
    logic [15:0] out;

    int n_assert;
    int n_fail;

    bound_flash_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .flick     (flick),
        .out_state (out_state),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] exp_out, input logic [3:0] exp_st);
        n_assert++;
        assert (out === exp_out) else begin
            n_fail++;
            $error("FAIL %s out: got %h expected %h", tag, out, exp_out);
        end
        n_assert++;
        assert (out_state === exp_st) else begin
            n_fail++;
            $error("FAIL %s out_state: got %0d expected %0d", tag, out_state, exp_st);
        end
    endtask

    task automatic run(input int n, input string tag, input logic [15:0] exp_out, input logic [3:0] exp_st);
        for (int i = 0; i < n; i++) tick();
        chk(tag, exp_out, exp_st);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b0;
        flick    = 1'b1;

        // reset with flick toggling
        tick();          chk("rst0", 16'h0000, 4'd0);
        flick = 1'b0;
        tick();          chk("rst1", 16'h0000, 4'd0);
        flick = 1'b1;
        tick();          chk("rst2", 16'h0000, 4'd0);

        // idle hold
        reset = 1'b1;
        flick = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i % 5 == 4) chk("idle", 16'h0000, 4'd0);
        end

        // full sequence, single-cycle flick
        flick = 1'b1;
        run(1,  "start",      16'h0000, 4'd1);
        flick = 1'b0;
        run(1,  "p1_first",   16'h0001, 4'd1);
        run(5,  "p1_lamp5",   16'h003F, 4'd1);
        run(10, "p1_full",    16'hFFFF, 4'd1);
        run(1,  "to_p2",      16'hFFFF, 4'd2);
        run(1,  "p2_first",   16'h7FFF, 4'd2);
        run(10, "p2_end",     16'h001F, 4'd2);
        run(1,  "to_p3",      16'h001F, 4'd3);
        run(6,  "p3_end",     16'h07FF, 4'd3);
        run(1,  "to_p4",      16'h07FF, 4'd4);
        run(11, "p4_end",     16'h0000, 4'd4);
        run(1,  "to_p5",      16'h0000, 4'd5);
        run(16, "p5_end",     16'hFFFF, 4'd5);
        run(1,  "to_p6",      16'hFFFF, 4'd6);
        run(15, "p6_last",    16'h0001, 4'd6);
        run(1,  "p6_end",     16'h0000, 4'd6);
        run(1,  "to_idle",    16'h0000, 4'd0);
        run(3,  "idle_again", 16'h0000, 4'd0);

        // kickback at lamp 10 in phase 1
        flick = 1'b1;
        run(1,  "k1_start",   16'h0000, 4'd1);
        flick = 1'b0;
        run(11, "k1_lamp10",  16'h07FF, 4'd1);
        flick = 1'b1;
        run(1,  "k1_kick",    16'h07FF, 4'd7);
        flick = 1'b0;
        run(1,  "k1_drain1",  16'h03FF, 4'd7);
        run(10, "k1_drained", 16'h0000, 4'd7);
        run(1,  "k1_back",    16'h0000, 4'd1);
        run(1,  "k1_refill",  16'h0001, 4'd1);
        run(15, "k1_full",    16'hFFFF, 4'd1);
        run(1,  "k1_to_p2",   16'hFFFF, 4'd2);
        run(11, "k1_p2_end",  16'h001F, 4'd2);
        run(1,  "k1_to_p3",   16'h001F, 4'd3);
        run(6,  "k3_lamp10",  16'h07FF, 4'd3);

        // kickback in phase 3
        flick = 1'b1;
        run(1,  "k3_kick",    16'h07FF, 4'd2);
        flick = 1'b0;
        run(6,  "k3_drained", 16'h001F, 4'd2);
        run(1,  "k3_to_p3",   16'h001F, 4'd3);
        run(6,  "k3_refill",  16'h07FF, 4'd3);
        run(1,  "k3_to_p4",   16'h07FF, 4'd4);
        run(11, "k3_p4_end",  16'h0000, 4'd4);
        run(1,  "k3_to_p5",   16'h0000, 4'd5);
        run(8,  "p5_mid",     16'h00FF, 4'd5);

        // reset mid-phase-5
        reset = 1'b0;
        run(1,  "mid_rst",    16'h0000, 4'd0);
        reset = 1'b1;
        run(2,  "post_rst",   16'h0000, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
